uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` requesters. It latches one requester's packet and drives the transmitter's data and send inputs. It holds send long enough for the transmitter's divided serial clock to sample it. It then blocks further grants for a fixed frame time, because the transmitter reports no completion. It sits between the system's message sources and the transmitter, on the fast `clk` domain.

---
 rtl/uart_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between NUM_REQ requesters.
// Captures one packet per grant and pulses the requester's ack. Drives the
// transmitter's data/send inputs. Holds send for two serial-clock periods,
// then blocks further grants until a full frame time has elapsed.
// Build option: define UART_SCHED_RR_EN for round-robin arbitration;
// without it the lowest asserted index wins.
module uart_tx_sched #(
   parameter int NUM_REQ         = 4,
   parameter int packetSize      = 16,
   parameter int cycleDiv        = 100,
   parameter int propDelayOffset = 1
) (
   input  logic                             clk,
   input  logic                             rstN,
   input  logic [NUM_REQ-1:0]               reqValid,
   input  logic [NUM_REQ*packetSize-1:0]    reqData,
   output logic [NUM_REQ-1:0]               reqAck,
   output logic [packetSize-1:0]            txData,
   output logic                             txSend,
   output logic                             busy,
   output logic [$clog2(NUM_REQ)-1:0]       gntIdx
);
   localparam int IW        = $clog2(NUM_REQ);
   localparam int HOLD_CYC  = 2 * cycleDiv;
   localparam int FRAME_CYC = (packetSize + propDelayOffset + 2) * cycleDiv;
   localparam int CW        = $clog2(FRAME_CYC + 1);
   localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYC);
   localparam logic [CW-1:0] FRAME_C = CW'(FRAME_CYC);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [packetSize-1:0]  txData_q, txData_d;
   logic                   txSend_q, txSend_d;
   logic [NUM_REQ-1:0]     reqAck_q, reqAck_d;
   logic [IW-1:0]          gntIdx_q, gntIdx_d;

   logic                   win_found;
   logic [IW-1:0]          win_idx;
   logic [packetSize-1:0]  win_data;

`ifdef UART_SCHED_RR_EN
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW:0]            cand;

   // Round-robin pick: scan from the pointer, wrapping modulo NUM_REQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) begin
            cand = cand - (IW+1)'(NUM_REQ);
         end
         if (!win_found && reqValid[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end
`else
   // Fixed-priority pick: the lowest asserted index wins
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && reqValid[k]) begin
            win_found = 1'b1;
            win_idx   = IW'(k);
         end
      end
   end
`endif

   // Select the winner's packet slice
   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == IW'(k)) begin
            win_data = reqData[k*packetSize +: packetSize];
         end
      end
   end

   // Next-state and output logic: grant in IDLE, hold send, then wait out the frame
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      txData_d = txData_q;
      txSend_d = txSend_q;
      reqAck_d = '0;
      gntIdx_d = gntIdx_q;
`ifdef UART_SCHED_RR_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               txData_d = win_data;
               for (int k = 0; k < NUM_REQ; k++) begin
                  reqAck_d[k] = (win_idx == IW'(k));
               end
               gntIdx_d = win_idx;
               txSend_d = 1'b1;
               cnt_d    = CW'(1);
               state_d  = SEND;
`ifdef UART_SCHED_RR_EN
               if (win_idx == IW'(NUM_REQ - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = win_idx + IW'(1);
               end
`endif
            end
         end
         SEND: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == HOLD_C) begin
               txSend_d = 1'b0;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            // The counter parks at zero on the way back to IDLE so it never wraps
            if (cnt_q == FRAME_C) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, cleared synchronously while rstN is low
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         txData_q <= '0;
         txSend_q <= 1'b0;
         reqAck_q <= '0;
         gntIdx_q <= '0;
`ifdef UART_SCHED_RR_EN
         ptr_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         txData_q <= txData_d;
         txSend_q <= txSend_d;
         reqAck_q <= reqAck_d;
         gntIdx_q <= gntIdx_d;
`ifdef UART_SCHED_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign reqAck = reqAck_q;
   assign txData = txData_q;
   assign txSend = txSend_q;
   assign gntIdx = gntIdx_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios plus randomized traffic for uart_tx_sched.
// A frame-timing model (edges elapsed since the last grant) predicts every
// output on every cycle; directed scenarios add hand-computed expectations.
// Honours UART_SCHED_RR_EN to select the arbitration rule of the model.
module tb_uart_tx_sched;
   localparam int N     = 4;
   localparam int PS    = 8;
   localparam int HOLD  = 8;
   localparam int FRAME = 44;

   logic            clk = 1'b0;
   logic            rstN;
   logic [N-1:0]    reqValid;
   logic [N*PS-1:0] reqData;
   logic [N-1:0]    reqAck;
   logic [PS-1:0]   txData;
   logic            txSend;
   logic            busy;
   logic [1:0]      gntIdx;

   uart_tx_sched #(
      .NUM_REQ(N), .packetSize(PS), .cycleDiv(4), .propDelayOffset(1)
   ) dut (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData),
      .reqAck(reqAck), .txData(txData), .txSend(txSend), .busy(busy),
      .gntIdx(gntIdx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // model state: edges since the last grant (-1 = idle)
   int          m_age  = -1;
   int          m_ptr  = 0;
   int          m_gnt  = 0;
   logic [N-1:0]  m_ack  = '0;
   logic [PS-1:0] m_data = '0;

   int   gq[$];
   int   rise_q[$];
   logic prev_send = 1'b0;
   int   ack1_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef UART_SCHED_RR_EN
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
`else
      for (int k = 0; k < N; k++) begin
         if (v[k]) return k;
      end
`endif
      return 0;
   endfunction

   // behavioural model, advanced on every rising edge
   always @(posedge clk) begin
      int w;
      cyc++;
      if (!rstN) begin
         m_age = -1; m_ptr = 0; m_gnt = 0; m_ack = '0; m_data = '0;
      end else begin
         m_ack = '0;
         if (m_age < 0) begin
            if (reqValid != '0) begin
               w = pick(reqValid, m_ptr);
               m_ack[w] = 1'b1;
               m_data   = reqData[w*PS +: PS];
               m_gnt    = w;
               m_ptr    = (w + 1) % N;
               m_age    = 0;
            end
         end else begin
            m_age++;
            if (m_age >= FRAME) m_age = -1;
         end
      end
   end

   // compare process: every output, every cycle, 1 time unit after the edge
   always @(posedge clk) begin
      #1;
      chk("reqAck", 32'(reqAck), 32'(m_ack));
      chk("txData", 32'(txData), 32'(m_data));
      chk("txSend", 32'(txSend), 32'(m_age >= 0 && m_age < HOLD));
      chk("busy",   32'(busy),   32'(m_age >= 0));
      chk("gntIdx", 32'(gntIdx), 32'(m_gnt));
      if (reqAck != '0) begin
         gq.push_back(int'(gntIdx));
         $display("grant req=%0d data=%02h cycle=%0d", gntIdx, txData, cyc);
      end
      if (reqAck[1]) ack1_cnt++;
      if (txSend && !prev_send) rise_q.push_back(cyc);
      prev_send = txSend;
   end

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy !== 1'b0 && n < maxc) begin
         @(posedge clk); #2; n++;
      end
      chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   task automatic wait_grants(input int target, input int maxc);
      int n = 0;
      while (gq.size() < target && n < maxc) begin
         @(posedge clk); #2; n++;
      end
      chk("grant_timeout", 32'(gq.size()), 32'(target));
   endtask

   task automatic do_reset(input int ncyc);
      @(negedge clk); rstN = 1'b0;
      repeat (ncyc) @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int sends, busys, fall_c, ack_c, base;
      logic [PS-1:0] s0, s3;
      logic [N-1:0] v;
      logic [N*PS-1:0] d;

      rstN = 1'b0; reqValid = '0; reqData = '0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;

      // reset values
      @(posedge clk); #2;
      chk("rst_reqAck", 32'(reqAck), 32'(0));
      chk("rst_txData", 32'(txData), 32'(0));
      chk("rst_txSend", 32'(txSend), 32'(0));
      chk("rst_busy",   32'(busy),   32'(0));
      chk("rst_gntIdx", 32'(gntIdx), 32'(0));

      // single request from requester 2
      @(negedge clk);
      reqData  = {8'h3C, 8'hA5, 8'h11, 8'h22};
      reqValid = 4'b0100;
      @(posedge clk); #2;
      chk("single_ack",  32'(reqAck), 32'h4);
      chk("single_data", 32'(txData), 32'hA5);
      chk("single_gnt",  32'(gntIdx), 32'd2);
      sends = int'(txSend); busys = int'(busy);
      @(negedge clk); reqValid = '0;
      repeat (59) begin
         @(posedge clk); #2;
         sends += int'(txSend); busys += int'(busy);
      end
      chk("single_send_len", 32'(sends), 32'd8);
      chk("single_busy_len", 32'(busys), 32'd44);

      // all four held from a fresh reset
      do_reset(2);
      gq.delete(); rise_q.delete();
      @(negedge clk);
      reqData  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      reqValid = 4'b1111;
      wait_grants(5, 400);
      if (gq.size() >= 5) begin
`ifdef UART_SCHED_RR_EN
         chk("all_g0", 32'(gq[0]), 32'd0);
         chk("all_g1", 32'(gq[1]), 32'd1);
         chk("all_g2", 32'(gq[2]), 32'd2);
         chk("all_g3", 32'(gq[3]), 32'd3);
         chk("all_g4", 32'(gq[4]), 32'd0);
`else
         for (int i = 0; i < 5; i++) chk("all_fp", 32'(gq[i]), 32'd0);
`endif
      end
      if (rise_q.size() >= 5) begin
         for (int i = 1; i < 5; i++) chk("send_spacing", 32'(rise_q[i] - rise_q[i-1]), 32'd45);
      end
      @(negedge clk); reqValid = 4'b1110;
      wait_grants(6, 100);
      if (gq.size() >= 6) chk("drop0_next", 32'(gq[5]), 32'd1);
      @(negedge clk); reqValid = '0;
      wait_idle(100);

      // requester 3 arrives during WAIT of a grant to 0
      base = gq.size();
      @(negedge clk); reqValid = 4'b0001;
      wait_grants(base + 1, 20);
      @(negedge clk); reqValid = '0;
      repeat (20) @(negedge clk);
      s3 = PS'($urandom);
      reqData[3*PS +: PS] = s3;
      reqValid = 4'b1000;
      fall_c = -1; ack_c = -1;
      for (int n = 0; n < 100 && ack_c < 0; n++) begin
         @(posedge clk); #2;
         if (!busy && fall_c < 0) fall_c = cyc;
         if (reqAck != '0) ack_c = cyc;
      end
      chk("ack3_after_fall", 32'(ack_c - fall_c), 32'd1);
      chk("ack3_vec",  32'(reqAck), 32'h8);
      chk("ack3_data", 32'(txData), 32'(s3));
      @(negedge clk); reqValid = '0;
      wait_idle(100);

      // reset pulse at counter 5 of SEND, valid held throughout
      base = gq.size();
      @(negedge clk); reqValid = 4'b0010;
      wait_grants(base + 1, 20);
      repeat (4) @(posedge clk);
      @(negedge clk); rstN = 1'b0;
      @(posedge clk); #2;
      chk("rst_mid_send", 32'(txSend), 32'd0);
      chk("rst_mid_busy", 32'(busy),   32'd0);
      chk("rst_mid_data", 32'(txData), 32'd0);
      @(negedge clk); rstN = 1'b1;
      @(posedge clk); #2;
      chk("post_rst_ack", 32'(reqAck), 32'h2);
      @(negedge clk); reqValid = '0;
      wait_idle(100);

      // requester 1 withdraws during SEND of a grant to 0
      ack1_cnt = 0;
      base = gq.size();
      @(negedge clk);
      s0 = PS'($urandom);
      reqData[0 +: PS]  = s0;
      reqData[PS +: PS] = PS'($urandom);
      reqValid = 4'b0011;
      wait_grants(base + 1, 20);
      @(negedge clk);
      reqValid = '0;
      reqData[PS +: PS] = PS'($urandom);
      wait_idle(100);
      repeat (10) @(posedge clk);
      #2;
      chk("withdraw_no_ack1", 32'(ack1_cnt), 32'd0);
      chk("withdraw_hold",    32'(txData),   32'(s0));

      // randomized traffic following the requester protocol
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         v = reqValid; d = reqData;
         for (int i = 0; i < N; i++) begin
            if (v[i]) begin
               if (m_ack[i]) begin
                  if ($urandom_range(3) != 0) v[i] = 1'b0;
               end else if ($urandom_range(49) == 0) begin
                  v[i] = 1'b0;
               end
            end else if ($urandom_range(19) == 0) begin
               v[i] = 1'b1;
               d[i*PS +: PS] = PS'($urandom);
            end
         end
         if (c == 2000) rstN = 1'b0;
         if (c == 2003) rstN = 1'b1;
         reqValid = v; reqData = d;
      end
      @(negedge clk); reqValid = '0;
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
